arbiter_rr: RTL and testbench



---
 rtl/arbiter_rr_if.sv | 36 +++
 rtl/arbiter_rr.sv | 120 ++++++++++++
 tb/tb_arbiter_rr.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/arbiter_rr_if.sv
// Handshake bundle between the round-robin arbiter, its four input FIFOs
// and its four output FIFOs.
interface arbiter_rr_if #(
    parameter int WORD_SIZE = 6
);
    logic [3:0]             fifo_empty_in;
    logic [4*WORD_SIZE-1:0] data_in;
    logic [3:0]             almost_full_in;
    logic [3:0]             pop;
    logic [3:0]             push;
    logic [WORD_SIZE-1:0]   data_out;
    logic                   idle;
    logic [7:0]             word_count;

    modport slave (
        input  fifo_empty_in,
        input  data_in,
        input  almost_full_in,
        output pop,
        output push,
        output data_out,
        output idle,
        output word_count
    );

    modport master (
        output fifo_empty_in,
        output data_in,
        output almost_full_in,
        input  pop,
        input  push,
        input  data_out,
        input  idle,
        input  word_count
    );
endinterface

// File: rtl/arbiter_rr.sv
// Round-robin arbiter/router: pops one word per cycle from four input FIFOs
// and pushes it to the output FIFO selected by the word's destination field.
module arbiter_rr #(
    parameter int WORD_SIZE = 6,
    parameter int DEST_MSB  = WORD_SIZE - 1
) (
    input  logic        clk,
    input  logic        reset_L,
    arbiter_rr_if.slave bus
);

    function automatic logic [3:0] dec2(input logic [1:0] idx);
        logic [3:0] onehot;
        case (idx)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

    logic [3:0]           pop_r;
    logic [1:0]           last_r;
    logic                 valid1_r;
    logic [1:0]           sel1_r;
    logic [3:0]           push_r;
    logic [WORD_SIZE-1:0] data_out_r;
    logic [7:0]           word_count_r;
    logic                 idle_r;

    logic                 grant_s;
    logic [1:0]           grant_idx_s;
    logic [WORD_SIZE-1:0] word1_s;
    logic [1:0]           dest_s;

    assign grant_s = (bus.almost_full_in == 4'b0000) && (bus.fifo_empty_in != 4'b1111);

    // Cyclic scan from last_r+1; walking downwards lets the nearest candidate win.
    always_comb begin
        logic [1:0] cand;
        cand        = 2'd0;
        grant_idx_s = last_r;
        for (int k = 4; k >= 1; k--) begin
            cand        = last_r + 2'(k);
            grant_idx_s = bus.fifo_empty_in[cand] ? grant_idx_s : cand;
        end
    end

    // Word selection: the granted FIFO presents its word one cycle after pop.
    always_comb begin
        word1_s = {WORD_SIZE{1'b0}};
        case (sel1_r)
            2'd0:    word1_s = bus.data_in[0*WORD_SIZE +: WORD_SIZE];
            2'd1:    word1_s = bus.data_in[1*WORD_SIZE +: WORD_SIZE];
            2'd2:    word1_s = bus.data_in[2*WORD_SIZE +: WORD_SIZE];
            2'd3:    word1_s = bus.data_in[3*WORD_SIZE +: WORD_SIZE];
            default: word1_s = {WORD_SIZE{1'b0}};
        endcase
    end

    assign dest_s = word1_s[DEST_MSB -: 2];

    // Stage 0: registered grant and round-robin pointer.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pop_r  <= 4'b0000;
            last_r <= 2'd3;
        end else if (grant_s) begin
            pop_r  <= dec2(grant_idx_s);
            last_r <= grant_idx_s;
        end else begin
            pop_r  <= 4'b0000;
        end
    end

    // Stage 1: valid bit and source index; last_r names the queue popped this cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid1_r <= 1'b0;
            sel1_r   <= 2'd0;
        end else begin
            valid1_r <= |pop_r;
            sel1_r   <= last_r;
        end
    end

    // Stage 2: route to the destination FIFO; data_out holds when nothing is routed.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_r       <= 4'b0000;
            data_out_r   <= {WORD_SIZE{1'b0}};
            word_count_r <= 8'd0;
        end else if (valid1_r) begin
            push_r       <= dec2(dest_s);
            data_out_r   <= word1_s;
            word_count_r <= word_count_r + 8'd1;
        end else begin
            push_r       <= 4'b0000;
        end
    end

    // Idle flag: no pending input and an empty pipeline.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            idle_r <= 1'b1;
        end else begin
            idle_r <= (&bus.fifo_empty_in) && !valid1_r &&
                      (push_r == 4'b0000) && (pop_r == 4'b0000);
        end
    end

    assign bus.pop        = pop_r;
    assign bus.push       = push_r;
    assign bus.data_out   = data_out_r;
    assign bus.word_count = word_count_r;
    assign bus.idle       = idle_r;

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed bench for arbiter_rr with a behavioural model of the four input FIFOs.
module tb_arbiter_rr;
    localparam int W = 6;

    typedef struct {
        logic [1:0]   q;
        logic [W-1:0] word;
        logic [3:0]   exp_pop;
        logic [3:0]   exp_push;
    } vec_t;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    arbiter_rr_if #(.WORD_SIZE(W)) bus();
    arbiter_rr #(.WORD_SIZE(W)) dut (.clk(clk), .reset_L(reset_L), .bus(bus));

    logic [W-1:0] q [4][$];
    logic [W-1:0] din [4];
    logic [3:0]   pop_hold;
    int           n_vec = 0;
    int           n_bad = 0;
    vec_t         tbl [8];
    logic [3:0]   bp_pop  [11];
    logic [3:0]   bp_push [11];
    logic [W-1:0] bp_data [11];

    assign bus.data_in = {din[3], din[2], din[1], din[0]};

    // Input FIFO model: empty already accounts for this cycle's pop; the word
    // appears on data_in after the edge that performs the read.
    initial begin
        pop_hold = 4'b0000;
        for (int i = 0; i < 4; i++) din[i] = '0;
        bus.fifo_empty_in = 4'b1111;
        forever begin
            @(negedge clk); #2;
            pop_hold = bus.pop;
            for (int i = 0; i < 4; i++)
                bus.fifo_empty_in[i] = (q[i].size() <= (pop_hold[i] ? 1 : 0));
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (pop_hold[i]) begin
                    if (q[i].size() == 0) begin
                        n_bad++;
                        $display("FAIL pop_of_empty: queue %0d popped while empty", i);
                    end else begin
                        din[i] = q[i].pop_front();
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Loads every table word, then checks pop each cycle and push/data two cycles later.
    task automatic run_table(input int n);
        logic [3:0] ep;
        logic [3:0] eh;
        for (int i = 0; i < n; i++) q[tbl[i].q].push_back(tbl[i].word);
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk); #1;
            ep = (c <= n) ? tbl[c-1].exp_pop : 4'b0000;
            eh = (c >= 3 && c - 3 < n) ? tbl[c-3].exp_push : 4'b0000;
            chk($sformatf("tbl_pop[c%0d]", c), {28'd0, bus.pop}, {28'd0, ep});
            chk($sformatf("tbl_push[c%0d]", c), {28'd0, bus.push}, {28'd0, eh});
            if (c >= 3 && c - 3 < n)
                chk($sformatf("tbl_data[c%0d]", c), {26'd0, bus.data_out}, {26'd0, tbl[c-3].word});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_cycles;
        bus.almost_full_in = 4'b0000;
        reset_L = 1'b0;
        repeat (2) @(negedge clk); #1;
        chk("rst_pop",  {28'd0, bus.pop},  32'd0);
        chk("rst_push", {28'd0, bus.push}, 32'd0);
        chk("rst_data", {26'd0, bus.data_out}, 32'd0);
        chk("rst_cnt",  {24'd0, bus.word_count}, 32'd0);
        chk("rst_idle", {31'd0, bus.idle}, 32'd1);
        reset_L = 1'b1;
        @(negedge clk); #1;
        chk("idle_after_rel", {31'd0, bus.idle}, 32'd1);

        // Fairness: two words per queue, grants 0,1,2,3,0,1,2,3 with no gaps.
        tbl[0] = '{2'd0, 6'b00_0001, 4'b0001, 4'b0001};
        tbl[1] = '{2'd1, 6'b01_0010, 4'b0010, 4'b0010};
        tbl[2] = '{2'd2, 6'b10_0011, 4'b0100, 4'b0100};
        tbl[3] = '{2'd3, 6'b11_0100, 4'b1000, 4'b1000};
        tbl[4] = '{2'd0, 6'b11_0101, 4'b0001, 4'b1000};
        tbl[5] = '{2'd1, 6'b10_0110, 4'b0010, 4'b0100};
        tbl[6] = '{2'd2, 6'b01_0111, 4'b0100, 4'b0010};
        tbl[7] = '{2'd3, 6'b00_1000, 4'b1000, 4'b0001};
        run_table(8);
        chk("cnt_fair", {24'd0, bus.word_count}, 32'd8);

        // Routing: queue 0 carries destinations 0..3.
        tbl[0] = '{2'd0, 6'b00_1010, 4'b0001, 4'b0001};
        tbl[1] = '{2'd0, 6'b01_0101, 4'b0001, 4'b0010};
        tbl[2] = '{2'd0, 6'b10_1111, 4'b0001, 4'b0100};
        tbl[3] = '{2'd0, 6'b11_0000, 4'b0001, 4'b1000};
        run_table(4);
        chk("cnt_route", {24'd0, bus.word_count}, 32'd12);

        // Single queue: queue 2 with three dest-1 words.
        tbl[0] = '{2'd2, 6'b01_0001, 4'b0100, 4'b0010};
        tbl[1] = '{2'd2, 6'b01_0010, 4'b0100, 4'b0010};
        tbl[2] = '{2'd2, 6'b01_0011, 4'b0100, 4'b0010};
        run_table(3);
        chk("cnt_single", {24'd0, bus.word_count}, 32'd15);

        // Back-pressure: last grant was 2, so rotation runs 3,0 then stalls, then 1,2.
        bp_pop  = '{4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                    4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        bp_push = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000,
                    4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000};
        bp_data = '{6'b01_0011, 6'b01_0011, 6'b00_1001, 6'b01_1010, 6'b01_1010, 6'b01_1010,
                    6'b01_1010, 6'b01_1010, 6'b10_1011, 6'b11_1100, 6'b11_1100};
        q[0].push_back(6'b01_1010);
        q[1].push_back(6'b10_1011);
        q[2].push_back(6'b11_1100);
        q[3].push_back(6'b00_1001);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk); #1;
            chk($sformatf("bp_pop[c%0d]", c),  {28'd0, bus.pop},  {28'd0, bp_pop[c-1]});
            chk($sformatf("bp_push[c%0d]", c), {28'd0, bus.push}, {28'd0, bp_push[c-1]});
            chk($sformatf("bp_data[c%0d]", c), {26'd0, bus.data_out}, {26'd0, bp_data[c-1]});
            if (c == 2) bus.almost_full_in = 4'b0001;
            if (c == 6) bus.almost_full_in = 4'b0000;
        end
        chk("cnt_bp", {24'd0, bus.word_count}, 32'd19);

        // Reset mid-stream while push is active.
        for (int i = 1; i <= 4; i++) q[0].push_back({2'b10, 4'(i)});
        repeat (3) @(negedge clk);
        #1;
        chk("mid_push_active", {28'd0, bus.push}, 32'd4);
        reset_L = 1'b0;
        q[0].delete();
        #1;
        chk("mid_rst_pop",  {28'd0, bus.pop},  32'd0);
        chk("mid_rst_push", {28'd0, bus.push}, 32'd0);
        chk("mid_rst_data", {26'd0, bus.data_out}, 32'd0);
        chk("mid_rst_cnt",  {24'd0, bus.word_count}, 32'd0);
        chk("mid_rst_idle", {31'd0, bus.idle}, 32'd1);
        @(negedge clk); #1;
        reset_L = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); #1;
            chk($sformatf("post_rst_pop[c%0d]", c),  {28'd0, bus.pop},  32'd0);
            chk($sformatf("post_rst_push[c%0d]", c), {28'd0, bus.push}, 32'd0);
            chk($sformatf("post_rst_idle[c%0d]", c), {31'd0, bus.idle}, 32'd1);
        end

        // Counter wrap: 257 words through queue 1, pushed at cycles 3..259.
        for (int i = 0; i < 257; i++) q[1].push_back({2'b10, 4'(i)});
        bad_cycles = 0;
        for (int c = 1; c <= 257; c++) begin
            @(negedge clk); #1;
            if (bus.pop !== 4'b0010) bad_cycles++;
        end
        chk("wrap_pop_cycles", bad_cycles, 32'd0);
        @(negedge clk); #1;
        chk("wrap_pop_done", {28'd0, bus.pop}, 32'd0);
        chk("wrap_cnt_zero", {24'd0, bus.word_count}, 32'd0);
        @(negedge clk); #1;
        chk("wrap_last_push", {28'd0, bus.push}, 32'd4);
        chk("wrap_last_data", {26'd0, bus.data_out}, {26'd0, 6'b10_0000});
        chk("wrap_cnt_one", {24'd0, bus.word_count}, 32'd1);
        @(negedge clk); #1;
        chk("wrap_push_off", {28'd0, bus.push}, 32'd0);
        @(negedge clk); #1;
        chk("wrap_idle", {31'd0, bus.idle}, 32'd1);
        chk("wrap_cnt_final", {24'd0, bus.word_count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
